// File: rtl/bcd_tick_counter_pkg.sv
// Shared definitions for the BCD tick counter slice.
// - FSM state encoding (IDLE/RUN/PAUSE/DONE)
// - Active-low seven-segment constants (DE10-Lite order gfedcba)
// - Two-digit BCD value type with increment/decrement helpers
package bcd_tick_counter_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = S_IDLE,
        StRun   = S_RUN,
        StPause = S_PAUSE,
        StDone  = S_DONE
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

    localparam bcd2_t BCD_ZERO = '0;

    // Ones digit rolls 9 -> 0 and carries into tens.
    function automatic bcd2_t bcd_inc(input bcd2_t v);
        bcd2_t r;
        if (v.ones == 4'd9) begin
            r.ones = 4'd0;
            r.tens = v.tens + 4'd1;
        end else begin
            r.ones = v.ones + 4'd1;
            r.tens = v.tens;
        end
        return r;
    endfunction

    // Ones digit rolls 0 -> 9 and borrows from tens.
    function automatic bcd2_t bcd_dec(input bcd2_t v);
        bcd2_t r;
        if (v.ones == 4'd0) begin
            r.ones = 4'd9;
            r.tens = v.tens - 4'd1;
        end else begin
            r.ones = v.ones - 4'd1;
            r.tens = v.tens;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_tick_counter_if.sv
// Control and display bundle of the BCD tick counter.
// master: drives tick_clk/start/stop/clear/up_down/wrap_en, observes counter outputs.
// slave : the counter itself.
interface bcd_tick_counter_if;

    logic       tick_clk;
    logic       start;
    logic       stop;
    logic       clear;
    logic       up_down;
    logic       wrap_en;
    logic [3:0] count_ones;
    logic [3:0] count_tens;
    logic [6:0] hex0;
    logic [6:0] hex1;
    logic       running;
    logic       done;
    logic       tc_pulse;

    modport master (
        output tick_clk, start, stop, clear, up_down, wrap_en,
        input  count_ones, count_tens, hex0, hex1, running, done, tc_pulse
    );

    modport slave (
        input  tick_clk, start, stop, clear, up_down, wrap_en,
        output count_ones, count_tens, hex0, hex1, running, done, tc_pulse
    );

endinterface

// File: rtl/seg7_decode.sv
// BCD digit to active-low seven-segment decode (segment order gfedcba).
// Ports: bcd_i - 4-bit digit; seg_o - segments, low = lit. Codes 10..15 blank.
module seg7_decode
    import bcd_tick_counter_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_ZERO;
            4'd1:    seg_o = 7'b1111001;
            4'd2:    seg_o = 7'b0100100;
            4'd3:    seg_o = 7'b0110000;
            4'd4:    seg_o = 7'b0011001;
            4'd5:    seg_o = 7'b0010010;
            4'd6:    seg_o = 7'b0000010;
            4'd7:    seg_o = 7'b1111000;
            4'd8:    seg_o = 7'b0000000;
            4'd9:    seg_o = 7'b0010000;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_tick_counter.sv
// Two-digit BCD counter advanced by rising edges of a divided clock.
// Ports: clk_in - system clock; reset - async active-low reset;
//        bus    - slave side of bcd_tick_counter_if (tick_clk, run controls,
//                 BCD digits, HEX displays, running/done/tc_pulse status).
// tick_clk is treated as asynchronous data: synchronised, then edge-detected.
module bcd_tick_counter
    import bcd_tick_counter_pkg::*;
#(
    parameter int unsigned MAX_COUNT   = 59,  // terminal value, 1..99
    parameter int unsigned SYNC_STAGES = 2    // must be >= 2
) (
    input  logic                clk_in,
    input  logic                reset,
    bcd_tick_counter_if.slave   bus
);

    localparam bcd2_t MAX_BCD = '{tens: 4'(MAX_COUNT / 10), ones: 4'(MAX_COUNT % 10)};

    // ---------------------------------------------------------------------
    // Synchroniser and rising-edge detect
    // ---------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   tick;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.tick_clk};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign tick = sync_q[SYNC_STAGES-1] & ~hist_q;

    // ---------------------------------------------------------------------
    // Count step helpers
    // ---------------------------------------------------------------------
    state_e state_q;
    bcd2_t  cnt_q;
    logic   running_q;
    logic   done_q;
    logic   tc_q;

    logic   at_term;
    bcd2_t  step_cnt;
    bcd2_t  wrap_cnt;

    always_comb begin
        at_term  = bus.up_down ? (cnt_q == MAX_BCD) : (cnt_q == BCD_ZERO);
        wrap_cnt = bus.up_down ? BCD_ZERO : MAX_BCD;
        if (bus.up_down) begin
            // Digits are always 0..9, so a packed compare orders BCD values correctly.
            step_cnt = (cnt_q > MAX_BCD) ? BCD_ZERO : bcd_inc(cnt_q);
        end else begin
            step_cnt = bcd_dec(cnt_q);
        end
    end

    // ---------------------------------------------------------------------
    // Control FSM with registered outputs; priority clear > stop > start
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= BCD_ZERO;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            tc_q      <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            if (bus.clear) begin
                state_q   <= StIdle;
                cnt_q     <= BCD_ZERO;
                running_q <= 1'b0;
                done_q    <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (!bus.stop && bus.start) begin
                            state_q   <= StRun;
                            running_q <= 1'b1;
                        end
                    end
                    StRun: begin
                        if (bus.stop) begin
                            // A tick landing with stop is dropped, not deferred.
                            state_q   <= StPause;
                            running_q <= 1'b0;
                        end else if (tick) begin
                            if (at_term) begin
                                tc_q <= 1'b1;
                                if (bus.wrap_en) begin
                                    cnt_q <= wrap_cnt;
                                end else begin
                                    state_q   <= StDone;
                                    running_q <= 1'b0;
                                    done_q    <= 1'b1;
                                end
                            end else begin
                                cnt_q <= step_cnt;
                            end
                        end
                    end
                    StPause: begin
                        if (bus.start && !bus.stop) begin
                            state_q   <= StRun;
                            running_q <= 1'b1;
                        end
                    end
                    StDone: begin
                        // Only clear leaves DONE.
                    end
                    default: begin
                        state_q   <= StIdle;
                        running_q <= 1'b0;
                        done_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign bus.count_ones = cnt_q.ones;
    assign bus.count_tens = cnt_q.tens;
    assign bus.running    = running_q;
    assign bus.done       = done_q;
    assign bus.tc_pulse   = tc_q;

    seg7_decode u_seg_ones (
        .bcd_i (cnt_q.ones),
        .seg_o (bus.hex0)
    );

    seg7_decode u_seg_tens (
        .bcd_i (cnt_q.tens),
        .seg_o (bus.hex1)
    );

endmodule

// File: doc/bcd_tick_counter.md
Name: bcd_tick_counter

Overview:
- Consumer stage placed directly downstream of the clock divider.
- Samples the divided clock as a data signal in the fast clk_in domain and detects its rising edges as single-cycle ticks.
- Advances a 2-digit BCD counter on each tick under a run/pause/done control FSM.
- Drives two active-low seven-segment displays (DE10-Lite HEX format, segment order gfedcba).

Parameters:
- MAX_COUNT, 59, terminal value in decimal; legal range 1..99.
- SYNC_STAGES, 2, synchronizer depth for tick_clk; minimum 2.

Ports:
- clk_in  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous active-low reset.
- tick_clk  input  1  divided clock from upstream divider, treated as asynchronous data.
- start  input  1  level, sampled each cycle; requests RUN.
- stop  input  1  level, sampled each cycle; requests PAUSE.
- clear  input  1  level, sampled each cycle; returns to IDLE with count 00.
- up_down  input  1  1 = count up, 0 = count down.
- wrap_en  input  1  1 = wrap at terminal, 0 = stop at terminal.
- count_ones  output  4  BCD ones digit.
- count_tens  output  4  BCD tens digit.
- hex0  output  7  active-low segments for ones digit.
- hex1  output  7  active-low segments for tens digit.
- running  output  1  high in RUN.
- done  output  1  high in DONE.
- tc_pulse  output  1  one-cycle pulse when a tick is applied at the terminal value.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; count 00; running=0, done=0, tc_pulse=0; hex0=hex1=7'b1000000; synchronizer and history flops cleared to 0.
- Tick detect: tick_clk passes through SYNC_STAGES flops plus one history flop; tick = sync_out & ~history.
  - Exactly one tick per tick_clk rising edge, regardless of how long tick_clk stays high.
  - With SYNC_STAGES=2, the count changes on the 3rd clk_in rising edge after tick_clk is first sampled high.
- FSM states: IDLE, RUN, PAUSE, DONE. Control priority is clear > stop > start.
  - Any state, clear=1: go to IDLE, count=00, tick ignored.
  - IDLE, start=1: go to RUN.
  - RUN, stop=1: go to PAUSE; a tick arriving in the same cycle is discarded.
  - PAUSE, start=1 and stop=0: go to RUN.
  - RUN, tick at terminal with wrap_en=0: count is held, go to DONE.
  - DONE: left only via clear; start and stop are ignored.
- Counting (RUN and tick only):
  - Up: ones 9 → 0 with carry into tens.
  - Down: ones 0 → 9 with borrow from tens.
- Terminal value: MAX_COUNT when up_down=1; 00 when up_down=0.
- Tick at terminal:
  - tc_pulse=1 for exactly one cycle.
  - wrap_en=1: up wraps to 00, down wraps to MAX_COUNT; stay in RUN.
  - wrap_en=0: hold count, enter DONE.
- up_down changes: take effect on the next tick. If the count is above MAX_COUNT (cannot occur after reset), the next up tick loads 00.
- Outputs: count_ones, count_tens, running, done, tc_pulse are registered. hex0/hex1 are a combinational decode of the registered digits.
  - Decode 0..9 per the standard table.
  - Values 10..15 display blank (7'b1111111).
- Reset asserted mid-count: immediate return to reset values. After release, first ticks count only if start is asserted.

Decomposition:
- Shared package holds:
  - FSM state encoding localparams (S_IDLE=0, S_RUN=1, S_PAUSE=2, S_DONE=3).
  - Seven-segment constants: SEG_BLANK=7'b1111111, SEG_ZERO=7'b1000000.
- Sub-module seg7_decode (4-bit BCD in, 7-bit active-low out, combinational) is instantiated twice. It is reusable by other display blocks.

Test Plan:
- Reset, start=1, drive 5 tick_clk rising edges (each high ≥4 clk_in cycles) -> count 05, hex0=7'b0010010, hex1=7'b1000000, running=1.
- Run up from 09, one tick -> 10. Preset to 59 with MAX_COUNT=59, wrap_en=1, one tick -> 00 and tc_pulse high exactly 1 cycle.
- Up at 59, wrap_en=0, one tick -> count stays 59, done=1, running=0. Further ticks and start=1 -> no change. clear=1 -> IDLE, 00.
- Down from 00, wrap_en=1, one tick -> 59 with tc_pulse. Next tick -> 58.
- Hold tick_clk high for 20 cycles -> exactly one increment. stop asserted in the same cycle as tick -> no increment, PAUSE. start -> RUN, next tick increments.
- Assert reset mid-run at count 37 -> outputs return to reset values asynchronously, without waiting for a clk_in edge. clear, stop, and start all high together -> IDLE, 00.
